// File: rtl/control_pkg.sv
// control_pkg: shared constants and types for the registered decode unit.
// Holds opcode/funct codes, ALU select encodings, the control-word struct
// and the FSM state enum. Register fields in ctrl_t keep the full 5-bit
// instruction field widths; control_pipe narrows them to REG_AW when it
// packs the output word.
package control_pkg;

  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_RTYPE = 6'd7;

  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_MUL = 6'd50;

  typedef enum logic [1:0] {
    SEL_ADD = 2'b00,
    SEL_SUB = 2'b01,
    SEL_AND = 2'b10,
    SEL_OR  = 2'b11
  } sel_alu_e;

  // Flag byte, MSB first, in output-word order.
  typedef struct packed {
    logic     rf_wr;
    logic     alu1_mux;
    sel_alu_e sel_alu;
    logic     mul_st;
    logic     alu2_mux;
    logic     mem_wr;
    logic     mux_sel_wb;
  } ctrl_flags_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    ctrl_flags_t f;
  } ctrl_t;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/control_pipe_if.sv
// control_pipe_if: fetch -> decode handshake plus the decoded control word.
//   in_valid/instr  : fetch-side request (master drives)
//   in_ready        : decoder accepts this cycle
//   ctrl_valid/ctrl : registered control word {rs,rt,rd,flags}
//   mul_busy        : multiplier occupied
interface control_pipe_if #(
  parameter int REG_AW = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic                  ctrl_valid;
  logic [3*REG_AW+7:0]   ctrl;
  logic                  mul_busy;

  modport master (
    output in_valid, instr,
    input  in_ready, ctrl_valid, ctrl, mul_busy
  );

  modport slave (
    input  in_valid, instr,
    output in_ready, ctrl_valid, ctrl, mul_busy
  );
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational MIPS instruction decoder.
//   instr_i : 32-bit instruction word
//   ctrl_o  : decoded control word (ctrl_t)
//   rs_v_o  : rs is a real source operand
//   rt_v_o  : rt is a real source operand (R-type and SW only)
module control_decode
  import control_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        rs_v_o,
  output logic        rt_v_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_shamt;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    ctrl_o            = '0;
    ctrl_o.rs         = instr_i[25:21];
    ctrl_o.rt         = instr_i[20:16];
    ctrl_o.f.alu2_mux = 1'b1;
    rs_v_o            = 1'b1;
    rt_v_o            = 1'b0;
    case (op)
      OP_LW: begin
        ctrl_o.rd           = instr_i[20:16];
        ctrl_o.f.rf_wr      = 1'b1;
        ctrl_o.f.alu1_mux   = 1'b1;
        ctrl_o.f.mux_sel_wb = 1'b1;
      end
      OP_SW: begin
        ctrl_o.f.alu1_mux   = 1'b1;
        ctrl_o.f.mem_wr     = 1'b1;
        ctrl_o.f.mux_sel_wb = 1'b1;
        rt_v_o              = 1'b1;
      end
      OP_RTYPE: begin
        ctrl_o.rd      = instr_i[15:11];
        ctrl_o.f.rf_wr = 1'b1;
        rt_v_o         = 1'b1;
        case (fn)
          F_ADD: ctrl_o.f.sel_alu = SEL_ADD;
          F_SUB: ctrl_o.f.sel_alu = SEL_SUB;
          F_AND: ctrl_o.f.sel_alu = SEL_AND;
          F_OR:  ctrl_o.f.sel_alu = SEL_OR;
          F_MUL: begin
            ctrl_o.f.sel_alu  = SEL_ADD;
            ctrl_o.f.mul_st   = 1'b1;
            ctrl_o.f.alu2_mux = 1'b0;
          end
          default: ctrl_o.f.sel_alu = SEL_SUB;
        endcase
      end
      default: ;  // NOP: only alu2_mux set
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: registered decode stage with RAW scoreboard and multiplier
// occupancy FSM.
//   clk, rst_n : clock, async active-low reset
//   flush      : kills output, scoreboard and multiplier wait this cycle
//   bus        : control_pipe_if.slave (in_valid/in_ready/instr in,
//                ctrl_valid/ctrl/mul_busy out)
// Optional: CONTROL_PIPE_FORWARD_EN limits stalls to load-use against the
// youngest scoreboard entry; everything else is assumed forwarded.
module control_pipe
  import control_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MUL_LAT  = 4,
  parameter int SB_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  control_pipe_if.slave bus
);

  localparam int CW = 3*REG_AW + 8;
  localparam int MW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [0:0] S_RUN      = ST_RUN;
  localparam logic [0:0] S_MUL_WAIT = ST_MUL_WAIT;

  ctrl_t             dec;
  logic              rs_v, rt_v;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [CW-1:0]     ctrl_word;
  logic              hazard, accept;

  logic [0:0]        state_q, state_d;
  logic [MW-1:0]     cnt_q, cnt_d;
  logic              ctrl_valid_q;
  logic [CW-1:0]     ctrl_q;

  logic [SB_DEPTH-1:0]             sb_v_q, sb_v_d;
  logic [SB_DEPTH-1:0][REG_AW-1:0] sb_rd_q, sb_rd_d;
`ifdef CONTROL_PIPE_FORWARD_EN
  logic [SB_DEPTH-1:0]             sb_ld_q, sb_ld_d;
`endif

  control_decode u_dec (
    .instr_i (bus.instr),
    .ctrl_o  (dec),
    .rs_v_o  (rs_v),
    .rt_v_o  (rt_v)
  );

  assign rs        = dec.rs[REG_AW-1:0];
  assign rt        = dec.rt[REG_AW-1:0];
  assign rd        = dec.rd[REG_AW-1:0];
  assign ctrl_word = {rs, rt, rd, dec.f};

  // Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
`ifdef CONTROL_PIPE_FORWARD_EN
      if (i == 0 && sb_v_q[0] && sb_ld_q[0]) begin
`else
      if (sb_v_q[i]) begin
`endif
        if (rs_v && rs != '0 && rs == sb_rd_q[i]) hazard = 1'b1;
        if (rt_v && rt != '0 && rt == sb_rd_q[i]) hazard = 1'b1;
      end
    end
  end

  assign bus.in_ready   = !flush && (state_q == S_RUN) && !hazard;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.mul_busy   = (state_q == S_MUL_WAIT);

  // Multiplier occupancy: a mul holds the front end for MUL_LAT-1 extra
  // cycles; with MUL_LAT=1 the wait state is unreachable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (state_q == S_MUL_WAIT) begin
      if (cnt_q > MW'(1)) begin
        cnt_d = cnt_q - MW'(1);
      end else begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end else if (accept && dec.f.mul_st && (MUL_LAT > 1)) begin
      state_d = S_MUL_WAIT;
      cnt_d   = MW'(MUL_LAT - 1);
    end
  end

  // Scoreboard ages one slot per cycle; the oldest entry falls off the end.
  always_comb begin
    sb_v_d  = '0;
    sb_rd_d = '0;
`ifdef CONTROL_PIPE_FORWARD_EN
    sb_ld_d = '0;
`endif
    if (!flush) begin
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_v_d[i]  = sb_v_q[i-1];
        sb_rd_d[i] = sb_rd_q[i-1];
`ifdef CONTROL_PIPE_FORWARD_EN
        sb_ld_d[i] = sb_ld_q[i-1];
`endif
      end
      sb_v_d[0]  = accept && dec.f.rf_wr;
      sb_rd_d[0] = rd;
`ifdef CONTROL_PIPE_FORWARD_EN
      sb_ld_d[0] = accept && dec.f.rf_wr && dec.f.mux_sel_wb;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_q       <= '0;
      sb_v_q       <= '0;
      sb_rd_q      <= '0;
`ifdef CONTROL_PIPE_FORWARD_EN
      sb_ld_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_valid_q <= accept;
      if (accept) ctrl_q <= ctrl_word;
      sb_v_q       <= sb_v_d;
      sb_rd_q      <= sb_rd_d;
`ifdef CONTROL_PIPE_FORWARD_EN
      sb_ld_q      <= sb_ld_d;
`endif
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: table vectors, directed multi-cycle sequences and a
// randomized stream, all checked against a queue-based reference model.
module tb_control_pipe;
  localparam int REG_AW   = 5;
  localparam int MUL_LAT  = 4;
  localparam int SB_DEPTH = 3;
`ifdef CONTROL_PIPE_FORWARD_EN
  localparam int EXP_RAW = 0;
  localparam int EXP_LU  = 1;
`else
  localparam int EXP_RAW = 3;
  localparam int EXP_LU  = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  control_pipe_if #(.REG_AW(REG_AW)) if_i ();

  control_pipe #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .SB_DEPTH(SB_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd, input int fn);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; int age; bit ld; } wr_t;
  wr_t pend[$];   // writes issued within the last SB_DEPTH cycles
  int  busy = 0;  // remaining multiplier-occupied cycles

  function automatic void ref_dec(input logic [31:0] ins, output logic [22:0] w,
                                  output bit wr, output logic [4:0] rd, output bit ld,
                                  output bit mul, output bit rts);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic [7:0] fl;
    rd = 5'd0; ld = 0; mul = 0; rts = 0;
    case (op)
      6'd8: begin fl = 8'b1100_0101; rd = ins[20:16]; ld = 1; end
      6'd9: begin fl = 8'b0100_0111; rts = 1; end
      6'd7: begin
        rd = ins[15:11]; rts = 1;
        case (fn)
          6'd32: fl = 8'b1000_0100;
          6'd34: fl = 8'b1001_0100;
          6'd36: fl = 8'b1010_0100;
          6'd37: fl = 8'b1011_0100;
          6'd50: begin fl = 8'b1000_1000; mul = 1; end
          default: fl = 8'b1001_0100;
        endcase
      end
      default: fl = 8'b0000_0100;
    endcase
    wr = fl[7];
    w  = {ins[25:21], ins[20:16], rd, fl};
  endfunction

  function automatic bit ref_hazard(input logic [31:0] ins);
    logic [4:0] rs = ins[25:21];
    logic [4:0] rt = ins[20:16];
    bit rts = (ins[31:26] == 6'd7) || (ins[31:26] == 6'd9);
    foreach (pend[i]) begin
`ifdef CONTROL_PIPE_FORWARD_EN
      if (pend[i].age == 1 && pend[i].ld) begin
`else
      begin
`endif
        if (rs != 0 && rs == pend[i].rd) return 1;
        if (rts && rt != 0 && rt == pend[i].rd) return 1;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input bit fl, input bit acc, input bit wr,
                            input logic [4:0] rd, input bit ld, input bit mul);
    wr_t nq[$];
    if (fl) begin
      pend.delete();
      busy = 0;
      return;
    end
    foreach (pend[i]) begin
      if (pend[i].age < SB_DEPTH) begin
        wr_t e = pend[i];
        e.age++;
        nq.push_back(e);
      end
    end
    pend = nq;
    if (busy > 0) busy--;
    if (acc && wr) pend.push_back('{rd, 1, ld});
    if (acc && mul && MUL_LAT > 1) busy = MUL_LAT - 1;
  endtask

  task automatic model_reset();
    pend.delete();
    busy = 0;
  endtask

  // ---------------- drive / check one clock ----------------
  task automatic drive(input bit v, input logic [31:0] ins, input bit fl);
    if_i.in_valid = v;
    if_i.instr    = ins;
    flush         = fl;
  endtask

  task automatic cycle(output bit acc, output bit rdy);
    logic [22:0] w; bit wr, ld, mul, rts, er, fl; logic [4:0] rd;
    @(negedge clk);
    fl  = flush;
    er  = !fl && busy == 0 && !ref_hazard(if_i.instr);
    rdy = if_i.in_ready;
    chk("in_ready", if_i.in_ready, er);
    acc = if_i.in_valid && er;
    ref_dec(if_i.instr, w, wr, rd, ld, mul, rts);
    @(posedge clk); #1;
    model_step(fl, acc, wr, rd, ld, mul);
    chk("ctrl_valid", if_i.ctrl_valid, acc);
    if (acc) chk("ctrl", if_i.ctrl, w);
    chk("mul_busy", if_i.mul_busy, busy > 0);
  endtask

  task automatic tick();
    bit a, r;
    cycle(a, r);
  endtask

  // Present ins until it issues; return observed stall cycles (bounded).
  task automatic issue_count(input logic [31:0] ins, output int stalls);
    bit a, r;
    stalls = 0;
    a = 0;
    drive(1, ins, 0);
    for (int t = 0; t < 12 && !a; t++) begin
      cycle(a, r);
      if (!r) stalls++;
    end
    drive(0, ins, 0);
  endtask

  function automatic logic [31:0] rnd_instr();
    int s = $urandom_range(0, 9);
    int op, fn;
    int fns[7] = '{32, 34, 36, 37, 50, 0, 13};
    op = (s < 2) ? 8 : (s < 4) ? 9 : (s < 9) ? 7 : int'($urandom_range(0, 63));
    fn = fns[$urandom_range(0, 6)];
    return mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fn);
  endfunction

  typedef struct { logic [31:0] ins; logic [22:0] exp; } vec_t;
  vec_t vec[11];

  initial begin
    bit a, r, have;
    int st;
    logic [31:0] cur;

    vec[0]  = '{mk(8, 1, 2, 9, 0),     {5'd1,  5'd2,  5'd2,  8'b1100_0101}};
    vec[1]  = '{mk(9, 3, 4, 7, 0),     {5'd3,  5'd4,  5'd0,  8'b0100_0111}};
    vec[2]  = '{mk(7, 5, 6, 4, 32),    {5'd5,  5'd6,  5'd4,  8'b1000_0100}};
    vec[3]  = '{mk(7, 10, 11, 12, 34), {5'd10, 5'd11, 5'd12, 8'b1001_0100}};
    vec[4]  = '{mk(7, 1, 2, 3, 36),    {5'd1,  5'd2,  5'd3,  8'b1010_0100}};
    vec[5]  = '{mk(7, 4, 5, 6, 37),    {5'd4,  5'd5,  5'd6,  8'b1011_0100}};
    vec[6]  = '{mk(7, 8, 9, 10, 50),   {5'd8,  5'd9,  5'd10, 8'b1000_1000}};
    vec[7]  = '{mk(7, 1, 1, 1, 0),     {5'd1,  5'd1,  5'd1,  8'b1001_0100}};
    vec[8]  = '{mk(0, 3, 4, 5, 32),    {5'd3,  5'd4,  5'd0,  8'b0000_0100}};
    vec[9]  = '{mk(63, 31, 31, 31, 50),{5'd31, 5'd31, 5'd0,  8'b0000_0100}};
    vec[10] = '{mk(7, 2, 3, 0, 32),    {5'd2,  5'd3,  5'd0,  8'b1000_0100}};

    // reset state
    drive(0, 32'h0, 0);
    #12;
    chk("rst_ctrl_valid", if_i.ctrl_valid, 0);
    chk("rst_ctrl", if_i.ctrl, 0);
    chk("rst_mul_busy", if_i.mul_busy, 0);
    chk("rst_in_ready", if_i.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // decode table, each vector after a clearing flush
    for (int k = 0; k < 11; k++) begin
      drive(0, 32'h0, 1); tick();
      drive(1, vec[k].ins, 0); cycle(a, r);
      chk($sformatf("vec%0d_ctrl", k), if_i.ctrl, vec[k].exp);
    end

    // independent back-to-back stream: LW r2, SW r3, ADD r4=r5+r6
    drive(0, 32'h0, 1); tick();
    drive(1, mk(8, 1, 2, 0, 0), 0);  cycle(a, r); chk("ind_lw_rdy", r, 1);
    chk("ind_lw_rd", if_i.ctrl[12:8], 2);
    drive(1, mk(9, 10, 3, 0, 0), 0); cycle(a, r); chk("ind_sw_rdy", r, 1);
    chk("ind_sw_memwr", if_i.ctrl[1], 1);
    drive(1, mk(7, 5, 6, 4, 32), 0); cycle(a, r); chk("ind_add_rdy", r, 1);
    chk("ind_add_rd", if_i.ctrl[12:8], 4);
    drive(0, 32'h0, 0); tick();

    // RAW stall: ADD r1=r2+r3 then SUB r4=r1-r5
    drive(0, 32'h0, 1); tick();
    drive(1, mk(7, 2, 3, 1, 32), 0); tick();
    issue_count(mk(7, 1, 5, 4, 34), st);
    chk("raw_stalls", st, EXP_RAW);

    // load-use: LW r7 then ADD r8=r7+r0
    drive(0, 32'h0, 1); tick();
    drive(1, mk(8, 1, 7, 0, 0), 0); tick();
    issue_count(mk(7, 7, 0, 8, 32), st);
    chk("loaduse_stalls", st, EXP_LU);

    // multiplier occupancy
    drive(0, 32'h0, 1); tick();
    drive(1, mk(7, 2, 3, 9, 50), 0); tick();
    chk("mul_flags", if_i.ctrl[3:2], 2'b10);
    chk("mul_busy_now", if_i.mul_busy, 1);
    issue_count(mk(7, 4, 5, 6, 32), st);
    chk("mul_stalls", st, MUL_LAT - 1);

    // flush during MUL_WAIT with a dependent instruction waiting
    drive(0, 32'h0, 1); tick();
    drive(1, mk(7, 2, 3, 10, 50), 0); tick();
    drive(1, mk(7, 10, 10, 11, 32), 1); tick();
    chk("flush_ctrl_valid", if_i.ctrl_valid, 0);
    chk("flush_mul_busy", if_i.mul_busy, 0);
    drive(1, mk(7, 10, 10, 11, 32), 0); cycle(a, r);
    chk("flush_dep_ready", r, 1);

    // asynchronous reset mid-stream
    drive(0, 32'h0, 1); tick();
    drive(1, mk(7, 1, 2, 3, 50), 0); tick();
    chk("pre_rst_valid", if_i.ctrl_valid, 1);
    chk("pre_rst_busy", if_i.mul_busy, 1);
    drive(0, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", if_i.ctrl_valid, 0);
    chk("async_rst_busy", if_i.mul_busy, 0);
    chk("async_rst_ctrl", if_i.ctrl, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, mk(7, 3, 3, 3, 32), 0); cycle(a, r);
    chk("post_rst_ready", r, 1);
    chk("post_rst_valid", if_i.ctrl_valid, 1);

    // randomized stream; a stalled instruction is held until it issues
    have = 0;
    cur = 32'h0;
    for (int t = 0; t < 600; t++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        cur  = rnd_instr();
        have = 1;
      end
      drive(have, cur, $urandom_range(0, 19) == 0);
      cycle(a, r);
      if (a) have = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
